fifo_byte_serializer: RTL and testbench
=======================================

FIFO_BYTE_SERIALIZER -- requirements
Module: fifo_byte_serializer

Interface
REQ-001 Parameter: MSB_FIRST, default 0, byte order (0 = bits [7:0] sent first; 1 = bits [31:24] sent first).
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 Port: fifo_empty  input  1  empty flag of the upstream 32-bit FIFO.
REQ-005 Port: fifo_dout  input  32  upstream FIFO read data, registered, valid the cycle after a read is accepted.
REQ-006 Port: fifo_read  output  1  read request to the upstream FIFO; one pulse per word.
REQ-007 Port: byte_out  output  8  serialized byte.
REQ-008 Port: byte_valid  output  1  byte_out holds a valid byte.
REQ-009 Port: byte_ready  input  1  downstream accepts byte_out this cycle.
REQ-010 Port: busy  output  1  high whenever state is not IDLE.
REQ-011 Port: words_done  output  16  count of fully transmitted words.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD and SEND.
REQ-013 fifo_read SHALL be combinational: high in IDLE when fifo_empty=0, or in SEND on final-byte acceptance when fifo_empty=0; low otherwise.
REQ-014 fifo_read SHALL never be high while fifo_empty=1 or reset=1.
REQ-015 IDLE: when fifo_read=1, next state SHALL be LOAD; otherwise the FSM stays in IDLE.
REQ-016 LOAD: the block SHALL capture fifo_dout into a 32-bit shift register, clear the byte index to 0 and go to SEND; LOAD SHALL last exactly 1 cycle.
REQ-017 SEND: byte_valid SHALL be 1, and byte_out SHALL be the byte selected by the index (0..3) and MSB_FIRST.
REQ-018 Acceptance SHALL occur when byte_valid=1 and byte_ready=1; each acceptance increments the index by 1.
REQ-019 While byte_valid=1 and byte_ready=0, byte_out and byte_valid SHALL hold stable.
REQ-020 Acceptance at index 3 SHALL increment words_done by 1, wrapping from 0xFFFF to 0x0000.
REQ-021 After acceptance at index 3, the next state SHALL be LOAD if fifo_empty=0 (back-to-back prefetch via REQ-013), otherwise IDLE.
REQ-022 Latency: first byte_valid SHALL rise 2 cycles after the fifo_read cycle, giving a minimum of 5 cycles per word when byte_ready is held high.
REQ-023 byte_valid SHALL be 0 in IDLE and LOAD.
REQ-024 byte_out SHALL be 0x00 whenever byte_valid=0.
REQ-025 Changes on fifo_empty during LOAD or mid-word SHALL have no effect; only the data captured in LOAD is transmitted.

Reset
REQ-026 Reset SHALL force the following on the next posedge clk: state IDLE, index 0, shift register 0, words_done 0x0000.
REQ-027 While reset is held, outputs SHALL be fifo_read=0, byte_valid=0, byte_out=0x00 and busy=0.
REQ-028 Reset asserted mid-word SHALL abort the word; the partial word is discarded, not retransmitted and not counted.
REQ-029 After reset deasserts, the FSM SHALL resume normal operation from IDLE in the next cycle.

Verification
REQ-030 Single word, MSB_FIRST=0, FIFO holds 0xA1B2C3D4, byte_ready=1 -> one fifo_read pulse; bytes D4, C3, B2, A1 on consecutive cycles; words_done=1; then IDLE.
REQ-031 Same word with MSB_FIRST=1 -> bytes A1, B2, C3, D4.
REQ-032 Backpressure: byte_ready low for 3 cycles while byte C3 is presented -> C3 held stable for 4 cycles; no byte lost or duplicated.
REQ-033 Back-to-back: FIFO holds 0x00000001 and 0x00000002, byte_ready=1 -> second fifo_read coincides with the final-byte acceptance; 8 bytes delivered in 10 cycles; words_done=2.
REQ-034 Reset after 2 bytes of 0x11223344 accepted -> byte_valid=0 the next cycle; words_done=0; no fifo_read until fifo_empty=0 after reset release.
REQ-035 Empty FIFO held 20 cycles -> fifo_read never high; busy=0; byte_valid=0.

Source files
------------

// File: rtl/fifo_byte_serializer.sv
// fifo_byte_serializer: pops 32-bit words from an upstream FIFO and emits them as 4 bytes on a valid/ready stream.
// Latency: first byte_valid 2 cycles after the fifo_read pulse; 5 cycles per word minimum with byte_ready held high.
// Backpressure: byte_ready=0 holds byte_out/byte_valid stable; the next word is only fetched on final-byte acceptance.
//
// Ports:
//   clk         - single clock, all state on posedge
//   reset       - synchronous active-high reset
//   fifo_empty  - upstream FIFO empty flag
//   fifo_dout   - upstream FIFO read data, valid the cycle after fifo_read
//   fifo_read   - one-cycle read pulse per word (combinational)
//   byte_out    - serialized byte, 0x00 when byte_valid=0
//   byte_valid  - byte_out holds a valid byte
//   byte_ready  - downstream accepts byte_out this cycle
//   busy        - FSM is not idle
//   words_done  - count of fully transmitted words, wraps at 16 bits
module fifo_byte_serializer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_dout,
  output logic        fifo_read,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic [15:0] words_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_shift;
  logic [1:0]  r_idx;
  logic [15:0] r_words;

  logic        w_send;
  logic        w_accept;
  logic        w_last;
  logic [7:0]  w_byte;
  logic [31:0] w_shift_nxt;

  // Outputs are gated by reset so they read idle while reset is held,
  // even before the first clock edge has cleared the state.
  assign w_send   = (r_state == ST_SEND) && !reset;
  assign w_accept = w_send && byte_ready;
  assign w_last   = w_accept && (r_idx == 2'd3);

  // Prefetch on the final-byte acceptance keeps back-to-back words at 5 cycles.
  assign fifo_read = !reset && !fifo_empty && ((r_state == ST_IDLE) || w_last);

  // The outgoing byte always sits at one end of the shift register;
  // each acceptance shifts the next byte into that position.
  assign w_byte      = MSB_FIRST ? r_shift[31:24] : r_shift[7:0];
  assign w_shift_nxt = MSB_FIRST ? {r_shift[23:0], 8'h00} : {8'h00, r_shift[31:8]};

  assign byte_valid = w_send;
  assign byte_out   = w_send ? w_byte : 8'h00;
  assign busy       = !reset && (r_state != ST_IDLE);
  assign words_done = r_words;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_shift <= 32'h0;
      r_idx   <= 2'd0;
      r_words <= 16'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (fifo_read) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_shift <= fifo_dout;
          r_idx   <= 2'd0;
          r_state <= ST_SEND;
        end
        ST_SEND: begin
          if (w_accept) begin
            r_idx   <= r_idx + 2'd1;
            r_shift <= w_shift_nxt;
            if (r_idx == 2'd3) begin
              r_words <= r_words + 16'd1;
              r_state <= fifo_read ? ST_LOAD : ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// tb_fifo_byte_serializer: directed bench for both byte orders of fifo_byte_serializer.
// Latency: n/a (testbench).
// Backpressure: byte_ready driven per scenario; a small array models the upstream FIFO.
module tb_fifo_byte_serializer;

  logic        clk;
  logic        reset;
  logic        hide;
  logic        byte_ready;
  logic        fifo_empty;
  logic [31:0] fifo_dout = 32'h0;
  logic [31:0] mem [0:15];
  logic [3:0]  wr_ptr;
  logic [3:0]  rd_ptr = 4'd0;

  logic        rd0, bv0, busy0;
  logic [7:0]  bo0;
  logic [15:0] wd0;
  logic        rd1, bv1, busy1;
  logic [7:0]  bo1;
  logic [15:0] wd1;

  int vecs = 0;
  int errs = 0;

  // hide forces the empty flag high to disturb the DUT mid-word
  assign fifo_empty = (wr_ptr == rd_ptr) || hide;

  fifo_byte_serializer #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_read(rd0), .byte_out(bo0), .byte_valid(bv0), .byte_ready(byte_ready),
    .busy(busy0), .words_done(wd0)
  );

  fifo_byte_serializer #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_read(rd1), .byte_out(bo1), .byte_valid(bv1), .byte_ready(byte_ready),
    .busy(busy1), .words_done(wd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-output upstream FIFO, popped by the MSB_FIRST=0 instance
  always @(posedge clk) begin
    if (rd0) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 4'd1;
    end
  end

  task automatic push(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    push(32'hDEADBEEF);
    #1;
    vecs++; if (rd0 !== 1'b0) begin errs++; $display("FAIL rst_fifo_read got=%b exp=0", rd0); end
    vecs++; if (bv0 !== 1'b0) begin errs++; $display("FAIL rst_byte_valid got=%b exp=0", bv0); end
    vecs++; if (bo0 !== 8'h00) begin errs++; $display("FAIL rst_byte_out got=%h exp=00", bo0); end
    vecs++; if (busy0 !== 1'b0) begin errs++; $display("FAIL rst_busy got=%b exp=0", busy0); end
    vecs++; if (rd1 !== 1'b0) begin errs++; $display("FAIL rst_fifo_read_msb got=%b exp=0", rd1); end
    @(negedge clk); #1;
    vecs++; if (wd0 !== 16'h0) begin errs++; $display("FAIL rst_words_done got=%h exp=0000", wd0); end
    @(negedge clk);
    wr_ptr = rd_ptr;
    reset = 1'b0;
    #1;
    vecs++; if (busy0 !== 1'b0) begin errs++; $display("FAIL rst_rel_busy got=%b exp=0", busy0); end
    vecs++; if (rd0 !== 1'b0) begin errs++; $display("FAIL rst_rel_fifo_read got=%b exp=0", rd0); end
  endtask

  task automatic test_single();
    logic [7:0] e0 [4];
    logic [7:0] e1 [4];
    e0 = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    e1 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    @(negedge clk);
    push(32'hA1B2C3D4);
    byte_ready = 1'b1;
    #1;
    vecs++; if (rd0 !== 1'b1) begin errs++; $display("FAIL single_read got=%b exp=1", rd0); end
    vecs++; if (rd1 !== 1'b1) begin errs++; $display("FAIL single_read_msb got=%b exp=1", rd1); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); #1;
      if (k == 1) begin
        vecs++; if (bv0 !== 1'b0 || bo0 !== 8'h00) begin errs++; $display("FAIL single_load_out got=%b/%h exp=0/00", bv0, bo0); end
        vecs++; if (busy0 !== 1'b1) begin errs++; $display("FAIL single_load_busy got=%b exp=1", busy0); end
      end else if (k <= 5) begin
        vecs++; if (bv0 !== 1'b1 || bo0 !== e0[k-2]) begin errs++; $display("FAIL single_lsb_byte cyc=%0d got=%b/%h exp=1/%h", k, bv0, bo0, e0[k-2]); end
        vecs++; if (bv1 !== 1'b1 || bo1 !== e1[k-2]) begin errs++; $display("FAIL single_msb_byte cyc=%0d got=%b/%h exp=1/%h", k, bv1, bo1, e1[k-2]); end
        vecs++; if (rd0 !== 1'b0) begin errs++; $display("FAIL single_no_read cyc=%0d got=%b exp=0", k, rd0); end
        if (k == 5) begin
          vecs++; if (wd0 !== 16'd0) begin errs++; $display("FAIL single_wd_early got=%0d exp=0", wd0); end
        end
      end else begin
        vecs++; if (busy0 !== 1'b0 || bv0 !== 1'b0) begin errs++; $display("FAIL single_idle got=%b/%b exp=0/0", busy0, bv0); end
        vecs++; if (wd0 !== 16'd1 || wd1 !== 16'd1) begin errs++; $display("FAIL single_words got=%0d/%0d exp=1/1", wd0, wd1); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] got [$];
    logic [7:0] e0 [4];
    e0 = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    @(negedge clk);
    push(32'hA1B2C3D4);
    byte_ready = 1'b1;
    #1;
    vecs++; if (rd0 !== 1'b1) begin errs++; $display("FAIL bp_read got=%b exp=1", rd0); end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      byte_ready = !(k >= 3 && k <= 5);
      #1;
      if (bv0 && byte_ready) got.push_back(bo0);
      if (k >= 3 && k <= 6) begin
        vecs++; if (bv0 !== 1'b1 || bo0 !== 8'hC3) begin errs++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/c3", k, bv0, bo0); end
      end
    end
    byte_ready = 1'b1;
    vecs++; if (got.size() != 4) begin errs++; $display("FAIL bp_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      vecs++; if (got[i] !== e0[i]) begin errs++; $display("FAIL bp_seq idx=%0d got=%h exp=%h", i, got[i], e0[i]); end
    end
    vecs++; if (wd0 !== 16'd2 || busy0 !== 1'b0) begin errs++; $display("FAIL bp_end got=%0d/%b exp=2/0", wd0, busy0); end
  endtask

  task automatic test_back_to_back();
    logic       exp_v;
    int         idx;
    logic [7:0] e0, e1;
    @(negedge clk);
    push(32'h00000001);
    push(32'h00000002);
    byte_ready = 1'b1;
    #1;
    vecs++; if (rd0 !== 1'b1) begin errs++; $display("FAIL b2b_read0 got=%b exp=1", rd0); end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #1;
      exp_v = (k >= 2 && k <= 5) || (k >= 7 && k <= 10);
      vecs++; if (rd0 !== (k == 5)) begin errs++; $display("FAIL b2b_read cyc=%0d got=%b exp=%b", k, rd0, (k == 5)); end
      vecs++; if (bv0 !== exp_v) begin errs++; $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", k, bv0, exp_v); end
      if (exp_v) begin
        idx = (k <= 5) ? k - 2 : k - 3;
        e0 = (idx == 0) ? 8'h01 : (idx == 4) ? 8'h02 : 8'h00;
        e1 = (idx == 3) ? 8'h01 : (idx == 7) ? 8'h02 : 8'h00;
        vecs++; if (bo0 !== e0 || bo1 !== e1) begin errs++; $display("FAIL b2b_byte cyc=%0d got=%h/%h exp=%h/%h", k, bo0, bo1, e0, e1); end
      end
    end
    vecs++; if (wd0 !== 16'd4) begin errs++; $display("FAIL b2b_words got=%0d exp=4", wd0); end
  endtask

  task automatic test_midword_empty();
    logic       exp_v;
    int         idx;
    logic [7:0] e0 [8];
    e0 = '{8'h88, 8'h77, 8'h66, 8'h55, 8'hCC, 8'hBB, 8'hAA, 8'h99};
    @(negedge clk);
    push(32'h55667788);
    push(32'h99AABBCC);
    byte_ready = 1'b1;
    #1;
    vecs++; if (rd0 !== 1'b1) begin errs++; $display("FAIL mid_read0 got=%b exp=1", rd0); end
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      hide = (k == 1 || k == 3 || k == 8);
      #1;
      exp_v = (k >= 2 && k <= 5) || (k >= 7 && k <= 10);
      vecs++; if (rd0 !== (k == 5)) begin errs++; $display("FAIL mid_read cyc=%0d got=%b exp=%b", k, rd0, (k == 5)); end
      vecs++; if (bv0 !== exp_v) begin errs++; $display("FAIL mid_valid cyc=%0d got=%b exp=%b", k, bv0, exp_v); end
      if (exp_v) begin
        idx = (k <= 5) ? k - 2 : k - 3;
        vecs++; if (bo0 !== e0[idx]) begin errs++; $display("FAIL mid_byte cyc=%0d got=%h exp=%h", k, bo0, e0[idx]); end
      end
    end
    hide = 1'b0;
    vecs++; if (wd0 !== 16'd6 || busy0 !== 1'b0) begin errs++; $display("FAIL mid_end got=%0d/%b exp=6/0", wd0, busy0); end
  endtask

  task automatic test_reset_midword();
    logic [7:0] e0 [4];
    e0 = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
    @(negedge clk);
    push(32'h11223344);
    byte_ready = 1'b1;
    #1;
    vecs++; if (rd0 !== 1'b1) begin errs++; $display("FAIL rmid_read got=%b exp=1", rd0); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      if (k == 2) begin
        vecs++; if (bo0 !== 8'h44) begin errs++; $display("FAIL rmid_b0 got=%h exp=44", bo0); end
      end
      if (k == 3) begin
        vecs++; if (bo0 !== 8'h33) begin errs++; $display("FAIL rmid_b1 got=%h exp=33", bo0); end
      end
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    vecs++; if (bv0 !== 1'b0 || bo0 !== 8'h00) begin errs++; $display("FAIL rmid_held_out got=%b/%h exp=0/00", bv0, bo0); end
    vecs++; if (rd0 !== 1'b0 || busy0 !== 1'b0) begin errs++; $display("FAIL rmid_held_ctl got=%b/%b exp=0/0", rd0, busy0); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    vecs++; if (bv0 !== 1'b0 || busy0 !== 1'b0) begin errs++; $display("FAIL rmid_after got=%b/%b exp=0/0", bv0, busy0); end
    vecs++; if (wd0 !== 16'd0) begin errs++; $display("FAIL rmid_words got=%0d exp=0", wd0); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      vecs++; if (rd0 !== 1'b0) begin errs++; $display("FAIL rmid_no_read cyc=%0d got=%b exp=0", k, rd0); end
    end
    @(negedge clk);
    push(32'hCAFEF00D);
    #1;
    vecs++; if (rd0 !== 1'b1) begin errs++; $display("FAIL rmid_resume_read got=%b exp=1", rd0); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); #1;
      if (k >= 2 && k <= 5) begin
        vecs++; if (bv0 !== 1'b1 || bo0 !== e0[k-2]) begin errs++; $display("FAIL rmid_resume_byte cyc=%0d got=%b/%h exp=1/%h", k, bv0, bo0, e0[k-2]); end
      end
    end
    vecs++; if (wd0 !== 16'd1) begin errs++; $display("FAIL rmid_resume_words got=%0d exp=1", wd0); end
  endtask

  task automatic test_empty_idle();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      vecs++; if (rd0 !== 1'b0 || busy0 !== 1'b0) begin errs++; $display("FAIL empty_ctl cyc=%0d got=%b/%b exp=0/0", k, rd0, busy0); end
      vecs++; if (bv0 !== 1'b0 || bo0 !== 8'h00) begin errs++; $display("FAIL empty_out cyc=%0d got=%b/%h exp=0/00", k, bv0, bo0); end
    end
    vecs++; if (wd0 !== 16'd1) begin errs++; $display("FAIL empty_words got=%0d exp=1", wd0); end
  endtask

  initial begin
    reset      = 1'b1;
    hide       = 1'b0;
    byte_ready = 1'b0;
    wr_ptr     = 4'd0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_midword_empty();
    test_reset_midword();
    test_empty_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
